// File: rtl/cmd_phy_pkg.sv
// Shared types and helpers for the SD CMD-line PHY: state encoding, frame lengths
// and the serial CRC7 (x^7 + x^3 + 1) step function.
package cmd_phy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SEND       = 3'd1,
        ST_TURN       = 3'd2,
        ST_WAIT_START = 3'd3,
        ST_RECV       = 3'd4,
        ST_DONE       = 3'd5
    } state_t;

    localparam logic [6:0] CRC7_POLY     = 7'h09;
    localparam int         SHORT_FRAME_W = 48;
    localparam int         LONG_FRAME_W  = 136;

    function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic bit_in);
        logic fb;
        fb = bit_in ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7_serial.sv
// Bit-serial CRC7 accumulator, MSB-first; clear has priority over enable.
module sd_crc7_serial
    import cmd_phy_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic       bit_in,
    output logic [6:0] crc_out
);

    logic [6:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = '0;
        end else if (enable) begin
            crc_d = crc7_next(crc_q, bit_in);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_out = crc_q;

endmodule

// File: rtl/cmd_phy_param.sv
// SD-host CMD-line PHY: serialises command + CRC7 + end bit, then receives a short or long
// response. Define CMD_RESP_CRC_CHECK_EN to check the response CRC7 into crc_error.
module cmd_phy_param
    import cmd_phy_pkg::*;
#(
    parameter int CMD_W        = 40,
    parameter int SHORT_RESP_W = SHORT_FRAME_W,
    parameter int LONG_RESP_W  = LONG_FRAME_W,
    parameter int NCR_MIN      = 2,
    parameter int TIMEOUT_CYC  = 64
) (
    input  logic                   sd_clock,
    input  logic                   reset,
    input  logic                   strobe_in,
    input  logic                   ack_in,
    input  logic                   idle_in,
    input  logic                   no_response,
    input  logic                   long_resp,
    input  logic [CMD_W-1:0]       cmd_to_send,
    input  logic                   cmd_pin_in,
    output logic                   ack_out,
    output logic                   strobe_out,
    output logic [LONG_RESP_W-1:0] response,
    output logic                   command_timeout,
    output logic                   crc_error,
    output logic                   cmd_pin_out,
    output logic                   cmd_oe
);

    localparam int CNT_MAX_A = (CMD_W + 8 > LONG_RESP_W) ? CMD_W + 8 : LONG_RESP_W;
    localparam int CNT_MAX_B = (TIMEOUT_CYC > NCR_MIN) ? TIMEOUT_CYC : NCR_MIN;
    localparam int CNT_MAX   = (CNT_MAX_A > CNT_MAX_B) ? CNT_MAX_A : CNT_MAX_B;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SEND_CMD_END = CNT_W'(CMD_W);
    localparam logic [CNT_W-1:0] SEND_CRC_HI  = CNT_W'(CMD_W + 6);
    localparam logic [CNT_W-1:0] SEND_LAST    = CNT_W'(CMD_W + 7);
    localparam logic [CNT_W-1:0] TURN_LAST    = CNT_W'(NCR_MIN - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST    = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] SHORT_LAST   = CNT_W'(SHORT_RESP_W - 1);
    localparam logic [CNT_W-1:0] LONG_LAST    = CNT_W'(LONG_RESP_W - 1);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CMD_W-1:0]       cmd_q, cmd_d;
    logic                   no_resp_q, no_resp_d;
    logic                   long_q, long_d;
    logic [LONG_RESP_W-1:0] resp_q, resp_d;
    logic                   timeout_q, timeout_d;
    logic                   ack_q, ack_d;
    logic                   strobe_q, strobe_d;
    logic                   pin_q, pin_d;
    logic                   oe_q, oe_d;
    logic                   accept;
    logic                   tx_en;
    logic [6:0]             tx_crc;
    logic [CNT_W-1:0]       frame_last;

    assign frame_last = long_q ? LONG_LAST : SHORT_LAST;

    sd_crc7_serial u_tx_crc (
        .clk     (sd_clock),
        .reset   (reset),
        .clear   (accept),
        .enable  (tx_en),
        .bit_in  (cmd_q[CMD_W-1]),
        .crc_out (tx_crc)
    );

    // Pad outputs are registered from the current state, so the line lags the FSM by one cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        no_resp_d = no_resp_q;
        long_d    = long_q;
        resp_d    = resp_q;
        timeout_d = timeout_q;
        ack_d     = 1'b0;
        strobe_d  = 1'b0;
        pin_d     = 1'b1;
        oe_d      = 1'b0;
        accept    = 1'b0;
        tx_en     = 1'b0;
        if (idle_in) begin
            state_d = ST_IDLE;
            pin_d   = pin_q;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (strobe_in) begin
                        accept    = 1'b1;
                        cmd_d     = cmd_to_send;
                        no_resp_d = no_response;
                        long_d    = long_resp;
                        resp_d    = '0;
                        timeout_d = 1'b0;
                        ack_d     = 1'b1;
                        cnt_d     = '0;
                        state_d   = ST_SEND;
                    end
                end
                ST_SEND: begin
                    oe_d  = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q < SEND_CMD_END) begin
                        tx_en = 1'b1;
                        pin_d = cmd_q[CMD_W-1];
                        cmd_d = {cmd_q[CMD_W-2:0], 1'b0};
                    end else if (cnt_q <= SEND_CRC_HI) begin
                        pin_d = tx_crc[3'(SEND_CRC_HI - cnt_q)];
                    end
                    if (cnt_q == SEND_LAST) begin
                        cnt_d   = '0;
                        state_d = no_resp_q ? ST_DONE : ST_TURN;
                    end
                end
                ST_TURN: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == TURN_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_WAIT_START;
                    end
                end
                ST_WAIT_START: begin
                    cnt_d = cnt_q + 1'b1;
                    if (!cmd_pin_in) begin
                        resp_d  = {resp_q[LONG_RESP_W-2:0], 1'b0};
                        cnt_d   = CNT_W'(1);
                        state_d = ST_RECV;
                    end else if (cnt_q == WAIT_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = ST_DONE;
                    end
                end
                ST_RECV: begin
                    resp_d = {resp_q[LONG_RESP_W-2:0], cmd_pin_in};
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == frame_last) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    strobe_d = 1'b1;
                    // The ack only counts once the controller has actually seen strobe_out.
                    if (ack_in && strobe_q) begin
                        strobe_d = 1'b0;
                        state_d  = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge sd_clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            cmd_q     <= '0;
            no_resp_q <= 1'b0;
            long_q    <= 1'b0;
            resp_q    <= '0;
            timeout_q <= 1'b0;
            ack_q     <= 1'b0;
            strobe_q  <= 1'b0;
            pin_q     <= 1'b1;
            oe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            no_resp_q <= no_resp_d;
            long_q    <= long_d;
            resp_q    <= resp_d;
            timeout_q <= timeout_d;
            ack_q     <= ack_d;
            strobe_q  <= strobe_d;
            pin_q     <= pin_d;
            oe_q      <= oe_d;
        end
    end

`ifdef CMD_RESP_CRC_CHECK_EN
    localparam logic [CNT_W-1:0] SHORT_CRC_END = CNT_W'(SHORT_RESP_W - 8);
    localparam logic [CNT_W-1:0] LONG_CRC_LO   = CNT_W'(8);
    localparam logic [CNT_W-1:0] LONG_CRC_END  = CNT_W'(LONG_RESP_W - 8);

    logic [6:0] rx_crc;
    logic       rx_en;
    logic       crc_err_q, crc_err_d;

    // Short frames cover the start bit; long frames skip their 8-bit header.
    always_comb begin
        rx_en     = 1'b0;
        crc_err_d = crc_err_q;
        if (accept) begin
            crc_err_d = 1'b0;
        end else if (!idle_in) begin
            if (state_q == ST_WAIT_START && !cmd_pin_in) begin
                rx_en = !long_q;
            end else if (state_q == ST_RECV) begin
                rx_en = long_q ? (cnt_q >= LONG_CRC_LO && cnt_q < LONG_CRC_END)
                               : (cnt_q < SHORT_CRC_END);
                if (cnt_q == frame_last) begin
                    crc_err_d = (rx_crc != resp_d[7:1]);
                end
            end
        end
    end

    sd_crc7_serial u_rx_crc (
        .clk     (sd_clock),
        .reset   (reset),
        .clear   (accept),
        .enable  (rx_en),
        .bit_in  (cmd_pin_in),
        .crc_out (rx_crc)
    );

    always_ff @(posedge sd_clock) begin
        if (reset) begin
            crc_err_q <= 1'b0;
        end else begin
            crc_err_q <= crc_err_d;
        end
    end

    assign crc_error = crc_err_q;
`else
    assign crc_error = 1'b0;
`endif

    assign ack_out         = ack_q;
    assign strobe_out      = strobe_q;
    assign response        = resp_q;
    assign command_timeout = timeout_q;
    assign cmd_pin_out     = pin_q;
    assign cmd_oe          = oe_q;

endmodule
